// File: rtl/mem_access_stage.sv
// mem_access_stage: M stage of the pipeline. Issues data-memory requests,
// stalls the pipeline while memory is slow, abandons a request after
// TIMEOUT_CYCLES wait cycles, and holds the M->W pipeline register.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   *_M                    fields from the M pipeline register
//   dmem_valid/we/addr/wdata/be   data-memory request (addr word-aligned)
//   dmem_ready, dmem_rdata        memory completion and read data
//   stall_M                holds the F, D, E and M registers while high
//   *_W                    M->W pipeline register outputs
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable_RF_M,
  input  logic        write_enable_dmem_M,
  input  logic [1:0]  write_back_M,
  input  logic [31:0] alu_rsl_M,
  input  logic [31:0] imm_extended_M,
  input  logic [31:0] wd_M,
  input  logic [31:0] pc4_M,
  input  logic [4:0]  rd_M,
  input  logic [1:0]  store_sel_M,
  input  logic [2:0]  load_sel_M,
  output logic        dmem_valid,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_M,
  output logic        write_enable_RF_W,
  output logic        misalign_W,
  output logic        bus_err_W,
  output logic [1:0]  write_back_W,
  output logic [31:0] alu_rsl_W,
  output logic [31:0] read_data_W,
  output logic [31:0] imm_extended_W,
  output logic [31:0] pc4_W,
  output logic [4:0]  rd_W
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic        is_store, is_load, mem_op;
  logic        acc_half, acc_word;
  logic        misalign, req, timeout, abandon;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // Access decode. A store takes priority over the load select if both are set.
  always_comb begin
    is_store = write_enable_dmem_M;
    is_load  = (write_back_M == 2'b01) && !write_enable_dmem_M;
    mem_op   = is_store || is_load;
    acc_half = 1'b0;
    acc_word = 1'b0;
    if (is_store) begin
      acc_half = (store_sel_M == 2'b01);
      acc_word = store_sel_M[1];
    end else begin
      acc_half = (load_sel_M == 3'b001) || (load_sel_M == 3'b101);
      acc_word = !((load_sel_M == 3'b000) || (load_sel_M == 3'b100) || acc_half);
    end
    misalign = mem_op && ((acc_half && alu_rsl_M[0]) ||
                          (acc_word && (alu_rsl_M[1:0] != 2'b00)));
  end

  // wait_cnt counts completed WAIT cycles, so the current WAIT cycle is number
  // wait_cnt+1; the timeout fires in WAIT cycle number TIMEOUT_CYCLES.
  always_comb begin
    req        = mem_op && !misalign && !rst;
    timeout    = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    abandon    = req && timeout && !dmem_ready;
    dmem_valid = req && !abandon;
    stall_M    = req && !dmem_ready && !timeout;
  end

  // Request payload comes straight from the M register, which the stall holds
  // steady, so the payload is stable for the whole WAIT period.
  always_comb begin
    dmem_we    = dmem_valid && is_store;
    dmem_addr  = {alu_rsl_M[31:2], 2'b00};
    dmem_wdata = '0;
    dmem_be    = '1;
    if (is_store) begin
      case (store_sel_M)
        2'b00: begin
          dmem_wdata = {4{wd_M[7:0]}};
          dmem_be    = 4'b0001 << alu_rsl_M[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{wd_M[15:0]}};
          dmem_be    = alu_rsl_M[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = wd_M;
          dmem_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[{alu_rsl_M[1:0], 3'b000} +: 8];
    ld_half = alu_rsl_M[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (load_sel_M)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stall_M) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          if (stall_M) wait_cnt <= wait_cnt + 8'd1;
          else         state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable_RF_W <= 1'b0;
      misalign_W        <= 1'b0;
      bus_err_W         <= 1'b0;
      write_back_W      <= '0;
      alu_rsl_W         <= '0;
      read_data_W       <= '0;
      imm_extended_W    <= '0;
      pc4_W             <= '0;
      rd_W              <= '0;
    end else if (stall_M) begin
      write_enable_RF_W <= 1'b0;
      misalign_W        <= 1'b0;
      bus_err_W         <= 1'b0;
    end else begin
      write_enable_RF_W <= write_enable_RF_M && !misalign && !abandon;
      misalign_W        <= misalign;
      bus_err_W         <= abandon;
      write_back_W      <= write_back_M;
      alu_rsl_W         <= alu_rsl_M;
      read_data_W       <= (is_load && req && !abandon) ? load_data : '0;
      imm_extended_W    <= imm_extended_M;
      pc4_W             <= pc4_M;
      rd_W              <= rd_M;
    end
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning maximum WAIT cycles before a data-memory access is abandoned (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 write_enable_RF_M, write_enable_dmem_M  in  1 each  register-file write / store request from the M register.
REQ-005 write_back_M  in  2  result select: 00 ALU, 01 load data, 10 pc4, 11 immediate.
REQ-006 alu_rsl_M, imm_extended_M, wd_M, pc4_M  in  32 each  ALU result (memory address), immediate, store data, PC+4.
REQ-007 rd_M  in  5  destination register.
REQ-008 store_sel_M  in  2  store size: 00 byte, 01 half, 10 or 11 word.
REQ-009 load_sel_M  in  3  load type: 000 lb, 001 lh, 100 lbu, 101 lhu, any other code lw.
REQ-010 dmem_valid  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned, addr[1:0]=00); dmem_wdata  out  32; dmem_be  out  4  data-memory request channel.
REQ-011 dmem_ready  in  1; dmem_rdata  in  32  memory completion and read data.
REQ-012 stall_M  out  1  holds the F, D, E and M registers while high.
REQ-013 write_enable_RF_W, misalign_W, bus_err_W  out  1 each; write_back_W  out  2; alu_rsl_W, read_data_W, imm_extended_W, pc4_W  out  32 each; rd_W  out  5  M->W pipeline register outputs.

Function
REQ-014 Memory op is defined as write_enable_dmem_M=1 or write_back_M=01.
REQ-015 Misalignment is defined as a half access with addr[0]=1, or a word access with addr[1:0]!=00.
REQ-016 A misaligned memory op SHALL issue no request and no stall, and SHALL load W with misalign_W=1 and write_enable_RF_W=0.
REQ-017 FSM states SHALL be IDLE and WAIT; the reset state is IDLE.
REQ-018 In IDLE, an aligned memory op SHALL drive dmem_valid=1 combinationally in the same cycle.
REQ-019 In IDLE, if dmem_ready=1 in the same cycle, the access SHALL complete with zero added latency, stall_M=0, and state SHALL remain IDLE.
REQ-020 In IDLE, if dmem_ready=0, stall_M=1 and the FSM SHALL move to WAIT.
REQ-021 In WAIT, dmem_valid, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL be held stable, and stall_M=1 until completion.
REQ-022 In WAIT, dmem_ready=1 SHALL complete the access with stall_M=0 in that cycle and return the FSM to IDLE.
REQ-023 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-024 When the wait counter reaches TIMEOUT_CYCLES with dmem_ready still 0, the access SHALL be abandoned: dmem_valid=0 and stall_M=0 that cycle, W loaded with bus_err_W=1 and write_enable_RF_W=0, next state IDLE.
REQ-025 If dmem_ready and the timeout occur in the same cycle, dmem_ready SHALL win and the access completes normally.
REQ-026 Store byte: wdata = wd_M[7:0] replicated x4; be = 0001 << addr[1:0].
REQ-027 Store half: wdata = wd_M[15:0] replicated x2; be = 0011 if addr[1]=0, else 1100.
REQ-028 Store word: wdata = wd_M; be = 1111.
REQ-029 Loads SHALL drive dmem_we=0 and be=1111.
REQ-030 Load byte extraction: rdata byte lane addr[1:0]; half extraction: rdata half lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes all 32 bits.
REQ-031 On every non-stalled cycle, W SHALL capture all M fields, with read_data_W = extracted load data (0 for non-loads).
REQ-032 While stall_M=1, W SHALL capture a bubble: write_enable_RF_W=0, misalign_W=0, bus_err_W=0, other fields unchanged.
REQ-033 dmem_valid SHALL be 0 whenever no aligned memory op is pending.
REQ-034 dmem_valid SHALL be 0 in any cycle in which rst=1.

Reset
REQ-035 While rst=1 at a clock edge, every W output and the wait counter SHALL become 0 and the FSM SHALL become IDLE.
REQ-036 Reset asserted in WAIT SHALL abandon the access with no W write; stall_M SHALL be 0 in the cycle after reset.

Verification
REQ-037 sw with addr 0x100, wd 0x11223344, dmem_ready=1 in the same cycle -> dmem_be=1111, dmem_wdata=0x11223344, stall_M=0, no FSM transition.
REQ-038 lb at addr 0x103, rdata 0x80FF0000, ready=1 -> read_data_W=0xFFFFFF80; same access as lbu -> 0x00000080.
REQ-039 sh at addr 0x102, wd 0xABCD, ready delayed 3 cycles -> stall_M high for 3 cycles, be=1100, wdata=0xABCDABCD held stable, 3 bubbles in W, then store completes.
REQ-040 lw at addr 0x101 -> dmem_valid=0, misalign_W=1, write_enable_RF_W=0, stall_M=0.
REQ-041 TIMEOUT_CYCLES=4, ready never asserted -> stall released at the 4th WAIT cycle, bus_err_W=1, FSM returns to IDLE; a separate case with ready arriving in the timeout cycle -> normal completion.
REQ-042 rst pulsed in the 2nd WAIT cycle -> all W outputs 0, dmem_valid=0, stall_M=0 the following cycle.
